// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator-CPU control sequencer.
// Contents: opcode encodings, the phase-state enumeration (phases 0..7 plus
// HALTED), the strobe bundle driven into the datapath, and a helper that maps
// a state onto the externally visible 3-bit phase number.
package cpu_pkg;

    localparam int OP_CODE_WIDTH = 3;

    localparam logic [OP_CODE_WIDTH-1:0] HLT = 3'd0;
    localparam logic [OP_CODE_WIDTH-1:0] SKZ = 3'd1;
    localparam logic [OP_CODE_WIDTH-1:0] ADD = 3'd2;
    localparam logic [OP_CODE_WIDTH-1:0] AND = 3'd3;
    localparam logic [OP_CODE_WIDTH-1:0] XOR = 3'd4;
    localparam logic [OP_CODE_WIDTH-1:0] LDA = 3'd5;
    localparam logic [OP_CODE_WIDTH-1:0] STO = 3'd6;
    localparam logic [OP_CODE_WIDTH-1:0] JMP = 3'd7;

    // Phases 0..7 use their phase number as encoding; HALTED sits outside that range.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic ld_ac;
        logic inc_pc;
        logic ld_pc;
        logic wr;
        logic data_e;
        logic halt;
    } strobe_t;

    localparam strobe_t STROBES_OFF = '{default: 1'b0};

    // Visible phase number; HALTED reports phase 0.
    function automatic logic [2:0] phase_of(input state_e st);
        logic [2:0] ph;
        case (st)
            INST_ADDR:  ph = 3'd0;
            INST_FETCH: ph = 3'd1;
            INST_LOAD:  ph = 3'd2;
            IDLE:       ph = 3'd3;
            OP_ADDR:    ph = 3'd4;
            OP_FETCH:   ph = 3'd5;
            ALU_OP:     ph = 3'd6;
            STORE:      ph = 3'd7;
            default:    ph = 3'd0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer and the CPU datapath.
// master: the sequencer (consumes opcode/zero[/mem_ready], drives strobes,
//         halt, phase and instr_count).
// slave:  the datapath side (the reverse directions).
// Optional macro MEM_WAIT_EN adds the mem_ready handshake line.
interface cpu_sequencer_if import cpu_pkg::*; #(
    parameter int CNT_WIDTH = 16
);
    logic [OP_CODE_WIDTH-1:0] opcode;
    logic                     zero;
`ifdef MEM_WAIT_EN
    logic                     mem_ready;
`endif
    logic                     sel;
    logic                     rd;
    logic                     ld_ir;
    logic                     ld_ac;
    logic                     inc_pc;
    logic                     ld_pc;
    logic                     wr;
    logic                     data_e;
    logic                     halt;
    logic [2:0]               phase;
    logic [CNT_WIDTH-1:0]     instr_count;

`ifdef MEM_WAIT_EN
    modport master (
        input  opcode, zero, mem_ready,
        output sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt, phase, instr_count
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt, phase, instr_count
    );
`else
    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt, phase, instr_count
    );
    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt, phase, instr_count
    );
`endif

endinterface

// File: rtl/cpu_seq_decode.sv
// Combinational strobe decoder for the sequencer.
// Ports:
//   state     in  current FSM state
//   opcode    in  IR[7:5]; only looked at in phases 4..7
//   zero      in  accumulator==0
//   mem_ready in  memory handshake (tie to 1 when no wait states exist)
//   strobes   out datapath control bundle
// Pulse strobes in the stall-capable states (INST_LOAD, ALU_OP, STORE) are
// qualified with mem_ready so they fire once, on the completing cycle; level
// signals (sel, rd, wr, data_e) stay up for the whole stall.
module cpu_seq_decode import cpu_pkg::*; (
    input  state_e                   state,
    input  logic [OP_CODE_WIDTH-1:0] opcode,
    input  logic                     zero,
    input  logic                     mem_ready,
    output strobe_t                  strobes
);

    logic alu_s;
    logic skz_s;
    logic sto_s;
    logic jmp_s;
    logic hlt_s;

    // Opcode class flags; unknown opcodes fall to default and act as no-ops.
    always_comb begin
        alu_s = 1'b0;
        skz_s = 1'b0;
        sto_s = 1'b0;
        jmp_s = 1'b0;
        hlt_s = 1'b0;
        case (opcode)
            HLT:                hlt_s = 1'b1;
            SKZ:                skz_s = 1'b1;
            ADD, AND, XOR, LDA: alu_s = 1'b1;
            STO:                sto_s = 1'b1;
            JMP:                jmp_s = 1'b1;
            default:            alu_s = 1'b0;
        endcase
    end

    // Per-state strobe table.
    always_comb begin
        strobes = STROBES_OFF;
        case (state)
            INST_ADDR: begin
                strobes.sel = 1'b1;
            end
            INST_FETCH: begin
                strobes.sel = 1'b1;
                strobes.rd  = 1'b1;
            end
            INST_LOAD: begin
                strobes.sel   = 1'b1;
                strobes.rd    = 1'b1;
                strobes.ld_ir = mem_ready;
            end
            IDLE: begin
                strobes.sel   = 1'b1;
                strobes.rd    = 1'b1;
                strobes.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                strobes.inc_pc = 1'b1;
                strobes.halt   = hlt_s;
            end
            OP_FETCH: begin
                strobes.rd = alu_s;
            end
            ALU_OP: begin
                strobes.rd     = alu_s;
                strobes.inc_pc = skz_s & zero & mem_ready;
                strobes.ld_pc  = jmp_s & mem_ready;
                strobes.data_e = sto_s;
            end
            STORE: begin
                strobes.rd     = alu_s;
                strobes.ld_ac  = alu_s & mem_ready;
                strobes.inc_pc = jmp_s & mem_ready;
                strobes.ld_pc  = jmp_s & mem_ready;
                strobes.wr     = sto_s;
                strobes.data_e = sto_s;
            end
            HALTED: begin
                strobes.halt = 1'b1;
            end
            default: begin
                strobes = STROBES_OFF;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator CPU.
// Each instruction walks phases 0..7 (one per clock); HLT in phase 4 parks
// the machine in HALTED until n_rst. Strobes are decoded from the state
// register by cpu_seq_decode; this module owns the state register and the
// saturating retired-instruction counter.
// Ports:
//   clk    in  system clock, rising edge
//   n_rst  in  asynchronous active-low reset
//   bus    master side of cpu_sequencer_if (opcode, zero, strobes, halt,
//          phase, instr_count)
// Optional macro MEM_WAIT_EN: INST_LOAD, ALU_OP and STORE wait for
// bus.mem_ready; without it those states always complete in one cycle.
module cpu_sequencer import cpu_pkg::*; #(
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    cpu_sequencer_if.master  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 ready_s;
    strobe_t              strobes_s;

`ifdef MEM_WAIT_EN
    assign ready_s = bus.mem_ready;
`else
    assign ready_s = 1'b1;
`endif

    cpu_seq_decode u_decode (
        .state     (state_r),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .mem_ready (ready_s),
        .strobes   (strobes_s)
    );

    // Phase state machine and saturating retired-instruction counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= INST_ADDR;
            count_r <= CNT_ZERO;
        end else begin
            case (state_r)
                INST_ADDR:  state_r <= INST_FETCH;
                INST_FETCH: state_r <= INST_LOAD;
                INST_LOAD: begin
                    if (ready_s) begin
                        state_r <= IDLE;
                    end
                end
                IDLE:       state_r <= OP_ADDR;
                OP_ADDR: begin
                    // HLT retires here since it never reaches STORE.
                    if (bus.opcode == HLT) begin
                        state_r <= HALTED;
                        count_r <= (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
                    end else begin
                        state_r <= OP_FETCH;
                    end
                end
                OP_FETCH:   state_r <= ALU_OP;
                ALU_OP: begin
                    if (ready_s) begin
                        state_r <= STORE;
                    end
                end
                STORE: begin
                    if (ready_s) begin
                        state_r <= INST_ADDR;
                        count_r <= (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
                    end
                end
                HALTED:     state_r <= HALTED;
                default:    state_r <= INST_ADDR;
            endcase
        end
    end

    assign bus.sel         = strobes_s.sel;
    assign bus.rd          = strobes_s.rd;
    assign bus.ld_ir       = strobes_s.ld_ir;
    assign bus.ld_ac       = strobes_s.ld_ac;
    assign bus.inc_pc      = strobes_s.inc_pc;
    assign bus.ld_pc       = strobes_s.ld_pc;
    assign bus.wr          = strobes_s.wr;
    assign bus.data_e      = strobes_s.data_e;
    assign bus.halt        = strobes_s.halt;
    assign bus.phase       = phase_of(state_r);
    assign bus.instr_count = count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer. The stimulus process walks
// instructions phase by phase, pushing the expected outputs of every cycle
// into a queue; the monitor pops and compares on each falling edge.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic [8:0]    strb;
        logic [2:0]    ph;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_WIDTH(CW)) bus ();
    cpu_sequencer #(.CNT_WIDTH(CW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   retired = 0;
    logic halted_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Reference strobe table {sel,rd,ld_ir,ld_ac,inc_pc,ld_pc,wr,data_e,halt}.
    function automatic logic [8:0] ref_strobes(input int p, input logic [2:0] op,
                                               input logic z, input logic rdy, input logic hlt);
        logic alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        logic sel = 1'b0, rd = 1'b0, ldir = 1'b0, ldac = 1'b0, inc = 1'b0;
        logic ldpc = 1'b0, wr = 1'b0, de = 1'b0, h = 1'b0;
        if (hlt) begin
            h = 1'b1;
        end else begin
            case (p)
                0: sel = 1'b1;
                1: begin sel = 1'b1; rd = 1'b1; end
                2: begin sel = 1'b1; rd = 1'b1; ldir = rdy; end
                3: begin sel = 1'b1; rd = 1'b1; ldir = 1'b1; end
                4: begin inc = 1'b1; h = (op == 3'd0); end
                5: rd = alu;
                6: begin
                    rd = alu; inc = (op == 3'd1) && z && rdy;
                    ldpc = (op == 3'd7) && rdy; de = (op == 3'd6);
                end
                7: begin
                    rd = alu; ldac = alu && rdy; inc = (op == 3'd7) && rdy;
                    ldpc = (op == 3'd7) && rdy; wr = (op == 3'd6); de = (op == 3'd6);
                end
                default: ;
            endcase
        end
        return {sel, rd, ldir, ldac, inc, ldpc, wr, de, h};
    endfunction

    function automatic logic [CW-1:0] cnt_exp();
        int m = (1 << CW) - 1;
        return CW'((retired > m) ? m : retired);
    endfunction

    function automatic int stall_len(input int forced);
`ifdef MEM_WAIT_EN
        return (forced >= 0) ? forced : int'($urandom_range(0, 2));
`else
        return 0;
`endif
    endfunction

    task automatic push_exp(input int p, input logic [2:0] op, input logic z, input logic rdy);
        exp_t e;
        e.strb = ref_strobes(p, op, z, rdy, halted_m);
        e.ph   = halted_m ? 3'd0 : 3'(p);
        e.cnt  = cnt_exp();
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs just after the edge and record what should be seen.
    task automatic cycle(input int p, input logic [2:0] op, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        bus.opcode = op;
        bus.zero   = z;
`ifdef MEM_WAIT_EN
        bus.mem_ready = rdy;
`endif
        push_exp(p, op, z, rdy);
        if (!halted_m && p == 7 && rdy) retired++;
        if (!halted_m && p == 4 && op == 3'd0) begin
            retired++;
            halted_m = 1'b1;
        end
    endtask

    // zmode: 0 -> zero low, 1 -> zero high, other -> random. alu_stall<0 -> random stalls.
    task automatic run_instr(input logic [2:0] op, input int first_p, input int last_p,
                             input int zmode, input int alu_stall);
        for (int p = first_p; p <= last_p; p++) begin
            int   ns;
            logic z;
            logic [2:0] drv;
            ns = 0;
            if (p == 6) ns = stall_len(alu_stall);
            else if (p == 2 || p == 7) ns = stall_len((alu_stall < 0) ? -1 : 0);
            for (int s = 0; s <= ns; s++) begin
                z   = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : 1'($urandom);
                drv = (p < 4) ? 3'($urandom) : op;
                cycle(p, drv, z, (s == ns));
            end
            if (halted_m) break;
        end
    endtask

    // Assert reset just after an edge, check the asynchronous effect, release before the next edge.
    task automatic reset_cycle();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("async_phase", 32'(bus.phase), 32'd0);
        check("async_sel", 32'(bus.sel), 32'd1);
        check("async_halt", 32'(bus.halt), 32'd0);
        check("async_count", 32'(bus.instr_count), 32'd0);
        retired  = 0;
        halted_m = 1'b0;
        push_exp(0, 3'd0, 1'b0, 1'b1);
        #5;
        n_rst = 1'b1;
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("strobes", 32'({bus.sel, bus.rd, bus.ld_ir, bus.ld_ac, bus.inc_pc,
                                  bus.ld_pc, bus.wr, bus.data_e, bus.halt}), 32'(mon_e.strb));
            check("phase", 32'(bus.phase), 32'(mon_e.ph));
            check("instr_count", 32'(bus.instr_count), 32'(mon_e.cnt));
        end
    end

    initial begin
        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        reset_cycle();
        run_instr(ADD, 1, 7, 0, 0);
        run_instr(SKZ, 0, 7, 1, 0);
        run_instr(SKZ, 0, 7, 0, 0);
        run_instr(STO, 0, 7, 2, 0);
        run_instr(LDA, 0, 7, 2, 3);
        repeat (20) run_instr(3'($urandom_range(7, 1)), 0, 7, 2, -1);
        run_instr(JMP, 0, 4, 2, 0);
        reset_cycle();
        run_instr(JMP, 1, 7, 2, 0);
        repeat (3) run_instr(3'($urandom_range(7, 1)), 0, 7, 2, -1);
        run_instr(HLT, 0, 7, 2, 0);
        repeat (24) cycle(0, 3'($urandom), 1'($urandom), 1'b1);
        reset_cycle();
        run_instr(XOR, 1, 7, 2, -1);
        run_instr(AND, 0, 7, 2, -1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator CPU: 3-bit opcode, 5-bit address, 8-bit data.
- Walks each instruction through 8 phases.
- Drives mux-select, load, increment and memory strobes into PC, IR, ACC, ALU and memory.
- Sits inside CPU beside the datapath. Takes opcode from the IR and the zero flag from the accumulator. Produces the CPU halt indication.

Parameters:
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- opcode  in  3  IR[7:5]. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator==0.
- sel  out  1  address mux: 1=PC, 0=IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  IR load strobe.
- ld_ac  out  1  ACC load strobe.
- inc_pc  out  1  PC increment strobe.
- ld_pc  out  1  PC load strobe (jump).
- wr  out  1  memory write enable.
- data_e  out  1  ACC drives data bus.
- halt  out  1  CPU halted, sticky until reset.
- phase  out  3  current phase 0..7.
- instr_count  out  CNT_WIDTH  retired instructions.

Behaviour:
- One clock `clk`; reset `n_rst` is asynchronous, active-low. On assertion: state INST_ADDR, instr_count=0, halt=0, phase=0.
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
- Sequence is 0→1→…→7→0, one state per clock. Exception: OP_ADDR with opcode=HLT goes to HALTED.
- ALUOP = ADD|AND|XOR|LDA.
- Outputs are combinational from state and opcode. Any strobe not listed for a state is 0.
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc; halt if HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=SKZ&zero; ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO.
- opcode is sampled only in phases 4–7, since the IR is stable after phase 2.
- HALTED:
  - halt=1; sel=0; all other strobes 0; phase=0.
  - Only n_rst exits this state.
- Instruction latency is fixed at 8 cycles.
- instr_count:
  - +1 on the STORE→INST_ADDR transition.
  - +1 on the OP_ADDR→HALTED transition, so HLT counts as retired.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-instruction aborts immediately and all outputs take reset values. The first post-reset rising edge moves to INST_FETCH.
- X/undefined opcode values are not tolerated. Decode defaults to no-op behaviour (no strobes beyond the fixed ones).

Optional Feature:
- Macro MEM_WAIT_EN adds input port mem_ready (1 bit).
- Stall-capable states are INST_LOAD, ALU_OP and STORE; they advance only when mem_ready=1.
- During a stall:
  - Level signals sel, rd, wr and data_e hold their values.
  - Strobes ld_ir, ld_ac, inc_pc and ld_pc are gated by mem_ready, so each fires exactly once in the completing cycle.
- instr_count increments only on the completing cycle.
- Without the macro the port is absent and behaviour equals mem_ready tied to 1.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams HLT..JMP;
  - the phase state enum/encodings, including HALTED;
  - OP_CODE_WIDTH=3.
- One sub-module, cpu_seq_decode: purely combinational. Maps state, opcode, zero (and mem_ready) to the strobe vector.
- The FSM register and counter stay in cpu_sequencer.

Test Plan:
- Release reset, opcode=ADD(2), zero=0 → strobes match the table over phases 0..7; ld_ac=1 only at phase 7; instr_count=1 after 8 cycles.
- opcode=SKZ(1):
  - zero=1 → inc_pc high in phases 4 and 6.
  - zero=0 → inc_pc high only in phase 4.
- opcode=STO(6) → data_e high in phases 6–7; wr high only in phase 7; rd low in phases 5–7.
- opcode=HLT(0) in phase 4 → halt=1 that cycle and stays 1 for 20+ cycles; all strobes 0; instr_count increments once.
- Pulse n_rst low at phase 5 of a JMP → phase=0, sel=1, instr_count=0 asynchronously, without waiting for a clock edge; clean restart.
- MEM_WAIT_EN, LDA with mem_ready=0 for 3 cycles in ALU_OP → phase stays 6 for 4 cycles, rd held; ld_ac fires once at phase 7.
